// File: rtl/quad_mux_74s258.sv
// rtl/quad_mux_74s258.sv - 74S258 quad 2-to-1 selector with tri-state outputs, optional output register
module quad_mux_74s258 #(
   parameter bit REGISTER_OUT = 1'b0,
   parameter bit INVERT       = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic SEL,
   input  logic ENB_N,
   input  logic A0,
   input  logic A1,
   input  logic B0,
   input  logic B1,
   input  logic C0,
   input  logic C1,
   input  logic D0,
   input  logic D1,
   output logic AY,
   output logic BY,
   output logic CY,
   output logic DY
);

   logic [3:0] in0;
   logic [3:0] in1;
   logic [3:0] sel_v;
   logic [3:0] val;
   logic [3:0] q;
   logic [3:0] y;

   assign in0 = {A0, B0, C0, D0};
   assign in1 = {A1, B1, C1, D1};

   // Vector ?: keeps bits where both inputs agree even if SEL is unknown
   assign sel_v = SEL ? in1 : in0;
   assign val   = INVERT ? ~sel_v : sel_v;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= 4'b0000;
      end else begin
         q <= val;
      end
   end

   assign y = REGISTER_OUT ? q : val;

   // Enable stays combinational in both modes
   assign AY = ENB_N ? 1'bz : y[3];
   assign BY = ENB_N ? 1'bz : y[2];
   assign CY = ENB_N ? 1'bz : y[1];
   assign DY = ENB_N ? 1'bz : y[0];

endmodule

// File: tb/tb_quad_mux_74s258.sv
// tb/tb_quad_mux_74s258.sv - self-checking bench for quad_mux_74s258 (combinational, registered, non-inverting)
module tb_quad_mux_74s258;

   logic       clk;
   logic       reset;
   logic       sel;
   logic       enb_n;
   logic [3:0] x0;
   logic [3:0] x1;
   wire  [3:0] y_c;
   wire  [3:0] y_r;
   wire  [3:0] y_n;

   int total;
   int bad;

   logic [3:0] exp_v;
   logic [3:0] zzzz;
   logic [3:0] q_model;

   quad_mux_74s258 #(.REGISTER_OUT(1'b0), .INVERT(1'b1)) dut_c (
      .clk(clk), .reset(reset), .SEL(sel), .ENB_N(enb_n),
      .A0(x0[3]), .A1(x1[3]), .B0(x0[2]), .B1(x1[2]),
      .C0(x0[1]), .C1(x1[1]), .D0(x0[0]), .D1(x1[0]),
      .AY(y_c[3]), .BY(y_c[2]), .CY(y_c[1]), .DY(y_c[0])
   );

   quad_mux_74s258 #(.REGISTER_OUT(1'b1), .INVERT(1'b1)) dut_r (
      .clk(clk), .reset(reset), .SEL(sel), .ENB_N(enb_n),
      .A0(x0[3]), .A1(x1[3]), .B0(x0[2]), .B1(x1[2]),
      .C0(x0[1]), .C1(x1[1]), .D0(x0[0]), .D1(x1[0]),
      .AY(y_r[3]), .BY(y_r[2]), .CY(y_r[1]), .DY(y_r[0])
   );

   quad_mux_74s258 #(.REGISTER_OUT(1'b0), .INVERT(1'b0)) dut_n (
      .clk(clk), .reset(reset), .SEL(sel), .ENB_N(enb_n),
      .A0(x0[3]), .A1(x1[3]), .B0(x0[2]), .B1(x1[2]),
      .C0(x0[1]), .C1(x1[1]), .D0(x0[0]), .D1(x1[0]),
      .AY(y_n[3]), .BY(y_n[2]), .CY(y_n[1]), .DY(y_n[0])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: pick the chosen 4-bit word, complement arithmetically when inverting
   function automatic logic [3:0] model(input logic s, input logic [3:0] a, input logic [3:0] b,
                                        input bit inv);
      int w;
      w = s ? int'(b) : int'(a);
      if (inv) w = 15 - w;
      return w[3:0];
   endfunction

   task automatic test_reset();
      enb_n = 1'b0; sel = 1'b0; x0 = 4'b1100; x1 = 4'b0011;
      @(posedge clk); #1;
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      total++;
      if (y_r !== 4'b0000) begin
         bad++; $display("FAIL reset_async y=%b exp=0000", y_r);
      end
      exp_v = model(sel, x0, x1, 1'b1);
      total++;
      if (y_c !== exp_v) begin
         bad++; $display("FAIL reset_comb_unaffected y=%b exp=%b", y_c, exp_v);
      end
      x0 = 4'b0110;
      @(posedge clk); #1;
      total++;
      if (y_r !== 4'b0000) begin
         bad++; $display("FAIL reset_hold y=%b exp=0000", y_r);
      end
      enb_n = 1'b1;
      #1;
      total++;
      if (y_r !== zzzz) begin
         bad++; $display("FAIL reset_tristate y=%b exp=zzzz", y_r);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      q_model = 4'b0000;
   endtask

   task automatic test_enable();
      enb_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sel = 1'($urandom_range(0, 1));
         x0  = 4'($urandom_range(0, 15));
         x1  = 4'($urandom_range(0, 15));
         #2;
         total++;
         if (y_c !== zzzz || y_r !== zzzz || y_n !== zzzz) begin
            bad++; $display("FAIL enable_z c=%b r=%b n=%b exp=zzzz", y_c, y_r, y_n);
         end
      end
   endtask

   task automatic test_select();
      enb_n = 1'b0; sel = 1'b0; x0 = 4'b0101; x1 = 4'b1010;
      #1;
      total++;
      if (y_c !== 4'b1010) begin
         bad++; $display("FAIL select_sel0 y=%b exp=1010", y_c);
      end
      sel = 1'b1;
      #1;
      total++;
      if (y_c !== 4'b0101) begin
         bad++; $display("FAIL select_sel1 y=%b exp=0101", y_c);
      end
   endtask

   task automatic test_sweep();
      enb_n = 1'b0; sel = 1'b0; x1 = 4'b0000;
      for (int v = 0; v < 16; v++) begin
         x0 = 4'(v);
         #1;
         exp_v = 4'(15 - v);
         total++;
         if (y_c !== exp_v) begin
            bad++; $display("FAIL sweep_x0 x0=%b y=%b exp=%b", x0, y_c, exp_v);
         end
      end
      sel = 1'b1; x0 = 4'b0000;
      for (int v = 0; v < 16; v++) begin
         x1 = 4'(v);
         #1;
         exp_v = 4'(15 - v);
         total++;
         if (y_c !== exp_v) begin
            bad++; $display("FAIL sweep_x1 x1=%b y=%b exp=%b", x1, y_c, exp_v);
         end
      end
      x1 = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         sel = (i == 1) ? 1'b0 : 1'b1;
         #1;
         exp_v = (i == 1) ? 4'b1111 : 4'b0000;
         total++;
         if (y_c !== exp_v) begin
            bad++; $display("FAIL sel_toggle step=%0d y=%b exp=%b", i, y_c, exp_v);
         end
      end
   endtask

   task automatic test_registered();
      logic [3:0] nxt;
      enb_n = 1'b0;
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      total++;
      if (y_r !== 4'b0000) begin
         bad++; $display("FAIL reg_reset y=%b exp=0000", y_r);
      end
      @(posedge clk); #1;
      reset = 1'b0; sel = 1'b0; x0 = 4'b0101; x1 = 4'b0000;
      #2;
      total++;
      if (y_r !== 4'b0000) begin
         bad++; $display("FAIL reg_latency y=%b exp=0000", y_r);
      end
      @(posedge clk); #1;
      total++;
      if (y_r !== 4'b1010) begin
         bad++; $display("FAIL reg_capture y=%b exp=1010", y_r);
      end
      q_model = 4'b1010;
      for (int i = 0; i < 24; i++) begin
         sel   = 1'($urandom_range(0, 1));
         enb_n = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
         x0    = 4'($urandom_range(0, 15));
         x1    = 4'($urandom_range(0, 15));
         #1;
         exp_v = enb_n ? zzzz : q_model;
         total++;
         if (y_r !== exp_v) begin
            bad++; $display("FAIL reg_hold i=%0d y=%b exp=%b", i, y_r, exp_v);
         end
         nxt = model(sel, x0, x1, 1'b1);
         @(posedge clk); #1;
         q_model = nxt;
         exp_v = enb_n ? zzzz : q_model;
         total++;
         if (y_r !== exp_v) begin
            bad++; $display("FAIL reg_random i=%0d y=%b exp=%b", i, y_r, exp_v);
         end
      end
   endtask

   task automatic test_noninvert();
      enb_n = 1'b0; sel = 1'b1; x0 = 4'b0000; x1 = 4'b1010;
      #1;
      total++;
      if (y_n !== 4'b1010) begin
         bad++; $display("FAIL noninvert_fixed y=%b exp=1010", y_n);
      end
      for (int i = 0; i < 16; i++) begin
         sel = 1'($urandom_range(0, 1));
         x0  = 4'($urandom_range(0, 15));
         x1  = 4'($urandom_range(0, 15));
         #1;
         exp_v = model(sel, x0, x1, 1'b0);
         total++;
         if (y_n !== exp_v) begin
            bad++; $display("FAIL noninvert_rand y=%b exp=%b", y_n, exp_v);
         end
         exp_v = model(sel, x0, x1, 1'b1);
         total++;
         if (y_c !== exp_v) begin
            bad++; $display("FAIL invert_rand y=%b exp=%b", y_c, exp_v);
         end
      end
   endtask

   initial begin
      total = 0; bad = 0;
      zzzz = 4'bzzzz;
      q_model = 4'b0000;
      reset = 1'b0; sel = 1'b0; enb_n = 1'b1; x0 = 4'b0000; x1 = 4'b0000;
      test_reset();
      test_enable();
      test_select();
      test_sweep();
      test_registered();
      test_noninvert();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
